window3x3_gen: RTL



---
 rtl/win3x3_pkg.sv | 17 +
 rtl/line_buf_ram.sv | 24 ++
 rtl/window3x3_gen.sv | 181 ++++++++++++++++++
 3 files changed

// File: rtl/win3x3_pkg.sv
// Shared constants for the 3x3 window generator: pipeline latency and tap offsets.
package win3x3_pkg;

    localparam int unsigned LAT = 2;

    // Bit offset of each window tap inside the packed window bus (p33 at LSB).
    function automatic int unsigned p11_idx(input int unsigned dw); return 8 * dw; endfunction
    function automatic int unsigned p12_idx(input int unsigned dw); return 7 * dw; endfunction
    function automatic int unsigned p13_idx(input int unsigned dw); return 6 * dw; endfunction
    function automatic int unsigned p21_idx(input int unsigned dw); return 5 * dw; endfunction
    function automatic int unsigned p22_idx(input int unsigned dw); return 4 * dw; endfunction
    function automatic int unsigned p23_idx(input int unsigned dw); return 3 * dw; endfunction
    function automatic int unsigned p31_idx(input int unsigned dw); return 2 * dw; endfunction
    function automatic int unsigned p32_idx(input int unsigned dw); return 1 * dw; endfunction
    function automatic int unsigned p33_idx(input int unsigned dw); return 0 * dw; endfunction

endpackage

// File: rtl/line_buf_ram.sv
// Simple dual-port line buffer: one-cycle registered read, read-before-write on address clash.
module line_buf_ram #(
    parameter int unsigned DEPTH = 800,
    parameter int unsigned DW    = 8,
    localparam int unsigned AW   = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [DW-1:0] wdata,
    input  logic          re,
    input  logic [AW-1:0] raddr,
    output logic [DW-1:0] rdata
);

    logic [DW-1:0] mem [DEPTH];

    // Write and read in the same edge; the read returns the pre-write contents.
    always_ff @(posedge clk) begin
        if (we) mem[waddr] <= wdata;
        if (re) rdata <= mem[raddr];
    end

endmodule

// File: rtl/window3x3_gen.sv
// 3x3 neighbourhood generator over a vsync/href/valid raster stream.
// Build macro WIN3X3_COORD_EN adds win_x/win_y centre-pixel coordinate outputs.
module window3x3_gen
    import win3x3_pkg::*;
#(
    parameter int unsigned DATA_W = 8,
    parameter int unsigned IMG_W  = 800,
    parameter int unsigned IMG_H  = 600,
    parameter int unsigned CNT_W  = 16
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                in_vsync,
    input  logic                in_href,
    input  logic                in_valid,
    input  logic [DATA_W-1:0]   in_data,
    output logic                out_vsync,
    output logic                out_href,
    output logic                out_valid,
    output logic [9*DATA_W-1:0] win,
    output logic                line_err,
    output logic                ovf_err
`ifdef WIN3X3_COORD_EN
    ,
    output logic [CNT_W-1:0]    win_x,
    output logic [CNT_W-1:0]    win_y
`endif
);

    localparam int unsigned AW = $clog2(IMG_W);
    localparam logic [CNT_W-1:0] IMG_W_C = CNT_W'(IMG_W);
    localparam logic [CNT_W-1:0] IMG_H_C = CNT_W'(IMG_H);
    localparam logic [CNT_W-1:0] TWO_C   = CNT_W'(2);

    logic [CNT_W-1:0]  col, row;
    logic              vs_q, href_q;
    logic              vs_rise_c, href_fall_c, acc_c, in_range_c, proc_c;
    logic [CNT_W-1:0]  col_eff_c, row_eff_c;

    logic              acc_d1, ctr_ok_d1;
    logic [DATA_W-1:0] data_d1;
    logic [AW-1:0]     addr_d1;
    logic [DATA_W-1:0] lb0_rd, lb1_rd;
    logic [LAT-1:0]    vs_pipe, href_pipe;
`ifdef WIN3X3_COORD_EN
    logic [CNT_W-1:0]  col_d1, row_d1;
`endif

    // Framing edges and the effective pixel coordinate (a vsync rise restarts at 0,0).
    always_comb begin
        vs_rise_c   = in_vsync & ~vs_q;
        href_fall_c = href_q & ~in_href;
        acc_c       = in_valid & in_href;
        col_eff_c   = vs_rise_c ? '0 : col;
        row_eff_c   = vs_rise_c ? '0 : row;
        in_range_c  = (col_eff_c < IMG_W_C) && (row_eff_c < IMG_H_C);
        proc_c      = acc_c & in_range_c;
    end

    // Column/row tracking: frame restart beats line end, line end beats pixel advance.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            col <= '0;
            row <= '0;
        end else if (vs_rise_c) begin
            col <= proc_c ? CNT_W'(1) : '0;
            row <= '0;
        end else if (href_fall_c) begin
            col <= '0;
            if (row < IMG_H_C) row <= row + CNT_W'(1);
        end else if (proc_c) begin
            col <= col + CNT_W'(1);
        end
    end

    // Edge-detect history and one-cycle error pulses.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            vs_q     <= 1'b0;
            href_q   <= 1'b0;
            line_err <= 1'b0;
            ovf_err  <= 1'b0;
        end else begin
            vs_q     <= in_vsync;
            href_q   <= in_href;
            line_err <= href_fall_c & (col != IMG_W_C);
            ovf_err  <= acc_c & ~in_range_c;
        end
    end

    // First pipeline stage: capture the accepted pixel and its buffer address.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            acc_d1    <= 1'b0;
            ctr_ok_d1 <= 1'b0;
            data_d1   <= '0;
            addr_d1   <= '0;
`ifdef WIN3X3_COORD_EN
            col_d1    <= '0;
            row_d1    <= '0;
`endif
        end else begin
            acc_d1 <= proc_c;
            if (proc_c) begin
                data_d1   <= in_data;
                addr_d1   <= AW'(col_eff_c);
                ctr_ok_d1 <= (col_eff_c >= TWO_C) && (row_eff_c >= TWO_C);
`ifdef WIN3X3_COORD_EN
                col_d1    <= col_eff_c;
                row_d1    <= row_eff_c;
`endif
            end
        end
    end

    line_buf_ram #(.DEPTH(IMG_W), .DW(DATA_W)) u_lb0 (
        .clk   (clk),
        .we    (acc_d1),
        .waddr (addr_d1),
        .wdata (data_d1),
        .re    (proc_c),
        .raddr (AW'(col_eff_c)),
        .rdata (lb0_rd)
    );

    line_buf_ram #(.DEPTH(IMG_W), .DW(DATA_W)) u_lb1 (
        .clk   (clk),
        .we    (acc_d1),
        .waddr (addr_d1),
        .wdata (lb0_rd),
        .re    (proc_c),
        .raddr (AW'(col_eff_c)),
        .rdata (lb1_rd)
    );

    // Second pipeline stage: shift a new column into the window on each delayed accept.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            win       <= '0;
`ifdef WIN3X3_COORD_EN
            win_x     <= '0;
            win_y     <= '0;
`endif
        end else begin
            out_valid <= acc_d1 & ctr_ok_d1;
            if (acc_d1) begin
                win[p11_idx(DATA_W) +: DATA_W] <= win[p12_idx(DATA_W) +: DATA_W];
                win[p12_idx(DATA_W) +: DATA_W] <= win[p13_idx(DATA_W) +: DATA_W];
                win[p13_idx(DATA_W) +: DATA_W] <= lb1_rd;
                win[p21_idx(DATA_W) +: DATA_W] <= win[p22_idx(DATA_W) +: DATA_W];
                win[p22_idx(DATA_W) +: DATA_W] <= win[p23_idx(DATA_W) +: DATA_W];
                win[p23_idx(DATA_W) +: DATA_W] <= lb0_rd;
                win[p31_idx(DATA_W) +: DATA_W] <= win[p32_idx(DATA_W) +: DATA_W];
                win[p32_idx(DATA_W) +: DATA_W] <= win[p33_idx(DATA_W) +: DATA_W];
                win[p33_idx(DATA_W) +: DATA_W] <= data_d1;
            end
`ifdef WIN3X3_COORD_EN
            if (acc_d1 & ctr_ok_d1) begin
                win_x <= col_d1 - CNT_W'(1);
                win_y <= row_d1 - CNT_W'(1);
            end
`endif
        end
    end

    // Sync outputs delayed to line up with the window pipeline.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            vs_pipe   <= '0;
            href_pipe <= '0;
        end else begin
            vs_pipe   <= {vs_pipe[LAT-2:0], in_vsync};
            href_pipe <= {href_pipe[LAT-2:0], in_href};
        end
    end

    assign out_vsync = vs_pipe[LAT-1];
    assign out_href  = href_pipe[LAT-1];

endmodule
